datapath: RTL and testbench

- 32-bit single-bus processor datapath: 16 GPRs, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, In/Out port registers, C sign-extension, CON flag and an ALU.
- Every register-transfer step is driven by an external control unit (or a bench) through one-hot out/in strobes, one transfer per clock.
- Sits between the control sequencer and the memory interface; memory read data enters on Mdatain.

---
 rtl/datapath_pkg.sv | 55 +++++
 rtl/datapath_if.sv | 35 +++
 rtl/datapath_alu.sv | 57 +++++
 rtl/datapath.sv | 126 ++++++++++++
 tb/tb_datapath.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: widths, opcodes, IR fields and bus sources.
package datapath_pkg;

    localparam int WORD = 32;
    localparam int NREG = 16;

    localparam int IR_OP_MSB  = 31;
    localparam int IR_OP_LSB  = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;
    localparam int IR_C_MSB   = 18;
    localparam int IR_CON_MSB = 20;
    localparam int IR_CON_LSB = 19;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;

    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_GPR,
        SRC_HI,
        SRC_LO,
        SRC_ZHI,
        SRC_ZLO,
        SRC_PC,
        SRC_MDR,
        SRC_INPORT,
        SRC_C
    } bus_src_t;

    function automatic logic [WORD-1:0] sign_extend_c(input logic [IR_C_MSB:0] c_field);
        return {{(WORD-IR_C_MSB-1){c_field[IR_C_MSB]}}, c_field};
    endfunction

endpackage

// File: rtl/datapath_if.sv
// Control/memory-side signal bundle between the sequencer (master) and the datapath (slave).
interface datapath_if;
    import datapath_pkg::*;

    logic            read;
    logic            write;
    logic [WORD-1:0] Mdatain;
    logic            PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
    logic            MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, InIn, OutIn;
    logic            IncPC;
    logic            CIn;
    logic            Gra, Grb, Grc;
    logic            RIn, Rout, BAout;
    logic [NREG-1:0] RegIn, Regout;
    logic [WORD-1:0] out_port;
    logic            con_out;
    logic [WORD-1:0] bus_mon;

    modport master (
        output read, write, Mdatain,
        output PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout,
        output MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, InIn, OutIn,
        output IncPC, CIn, Gra, Grb, Grc, RIn, Rout, BAout, RegIn, Regout,
        input  out_port, con_out, bus_mon
    );

    modport slave (
        input  read, write, Mdatain,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout,
        input  MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, InIn, OutIn,
        input  IncPC, CIn, Gra, Grb, Grc, RIn, Rout, BAout, RegIn, Regout,
        output out_port, con_out, bus_mon
    );

endinterface

// File: rtl/datapath_alu.sv
// Datapath ALU: A = Y, B = bus, 64-bit result feeding Z. Multiply/divide only built with MUL_DIV_EN.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WORD-1:0]   a,
    input  logic [WORD-1:0]   b,
    input  logic [4:0]        opcode,
    input  logic              inc_pc,
    output logic [2*WORD-1:0] result
);

    logic [4:0] shamt;
    logic [5:0] shamt_inv;

    assign shamt     = b[4:0];
    assign shamt_inv = 6'd32 - {1'b0, shamt};

`ifdef MUL_DIV_EN
    logic signed [2*WORD-1:0] product;
    logic signed [WORD-1:0]   quotient;
    logic signed [WORD-1:0]   remainder;

    assign product   = $signed({{WORD{a[WORD-1]}}, a}) * $signed({{WORD{b[WORD-1]}}, b});
    assign quotient  = $signed(a) / $signed(b);
    assign remainder = $signed(a) % $signed(b);
`endif

    // Rotates use a complementary shift; a shift by 32 yields zero so rotate-by-0 stays a.
    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[WORD-1:0] = b + 32'd1;
        end else begin
            case (opcode)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result[WORD-1:0] = a + b;
                OP_SUB:          result[WORD-1:0] = a - b;
                OP_AND, OP_ANDI: result[WORD-1:0] = a & b;
                OP_OR, OP_ORI:   result[WORD-1:0] = a | b;
                OP_SHR:          result[WORD-1:0] = a >> shamt;
                OP_SHL:          result[WORD-1:0] = a << shamt;
                OP_ROR:          result[WORD-1:0] = (a >> shamt) | (a << shamt_inv);
                OP_ROL:          result[WORD-1:0] = (a << shamt) | (a >> shamt_inv);
`ifdef MUL_DIV_EN
                OP_MUL:          result = product;
                OP_DIV: begin
                    if (b == '0) result = {a, 32'hFFFF_FFFF};
                    else         result = {remainder, quotient};
                end
`endif
                OP_NEG:          result[WORD-1:0] = -b;
                OP_NOT:          result[WORD-1:0] = ~b;
                default:         result = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath driven one transfer per clock by external strobes.
// Define MUL_DIV_EN to build the multiply/divide hardware in the ALU.
module datapath
    import datapath_pkg::*;
(
    input logic       clk,
    input logic       clr,
    datapath_if.slave cu
);

    logic [WORD-1:0]   gpr [NREG];
    logic [WORD-1:0]   pc, ir, mar, mdr, y, hi, lo, in_port, out_reg;
    logic [2*WORD-1:0] z;
    logic              con;

    logic [WORD-1:0]   bus;
    logic [WORD-1:0]   c_sext;
    logic [2*WORD-1:0] alu_result;
    logic [3:0]        reg_idx;
    logic [NREG-1:0]   reg_dec, reg_load, reg_drive, reg_base, gpr_active;
    logic [3:0]        gpr_sel;
    bus_src_t          bus_src;
    logic              con_next;

    assign reg_idx = ({4{cu.Gra}} & ir[IR_RA_MSB:IR_RA_LSB])
                   | ({4{cu.Grb}} & ir[IR_RB_MSB:IR_RB_LSB])
                   | ({4{cu.Grc}} & ir[IR_RC_MSB:IR_RC_LSB]);
    assign reg_dec    = NREG'(1) << reg_idx;
    assign reg_load   = ({NREG{cu.RIn}}  & reg_dec) | cu.RegIn;
    assign reg_drive  = ({NREG{cu.Rout}} & reg_dec) | cu.Regout;
    assign reg_base   = {NREG{cu.BAout}} & reg_dec;
    assign gpr_active = reg_drive | reg_base;
    assign c_sext     = sign_extend_c(ir[IR_C_MSB:0]);

    // Lowest-numbered active GPR wins, then the fixed special-register order.
    always_comb begin
        bus_src = SRC_NONE;
        gpr_sel = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (gpr_active[i]) gpr_sel = 4'(i);
        end
        if (|gpr_active)        bus_src = SRC_GPR;
        else if (cu.HIout)      bus_src = SRC_HI;
        else if (cu.LOout)      bus_src = SRC_LO;
        else if (cu.Zhighout)   bus_src = SRC_ZHI;
        else if (cu.Zlowout)    bus_src = SRC_ZLO;
        else if (cu.PCout)      bus_src = SRC_PC;
        else if (cu.MDRout)     bus_src = SRC_MDR;
        else if (cu.IN_Portout) bus_src = SRC_INPORT;
        else if (cu.Cout)       bus_src = SRC_C;
    end

    // R0 reached only through BAout reads as zero for base-address arithmetic.
    always_comb begin
        bus = '0;
        case (bus_src)
            SRC_GPR:    bus = (gpr_sel == 4'd0 && !reg_drive[0]) ? '0 : gpr[gpr_sel];
            SRC_HI:     bus = hi;
            SRC_LO:     bus = lo;
            SRC_ZHI:    bus = z[2*WORD-1:WORD];
            SRC_ZLO:    bus = z[WORD-1:0];
            SRC_PC:     bus = pc;
            SRC_MDR:    bus = mdr;
            SRC_INPORT: bus = in_port;
            SRC_C:      bus = c_sext;
            default:    bus = '0;
        endcase
    end

    always_comb begin
        con_next = 1'b0;
        case (ir[IR_CON_MSB:IR_CON_LSB])
            2'b00: con_next = (bus == '0);
            2'b01: con_next = (bus != '0);
            2'b10: con_next = !bus[WORD-1];
            2'b11: con_next = bus[WORD-1];
            default: con_next = 1'b0;
        endcase
    end

    datapath_alu u_alu (
        .a      (y),
        .b      (bus),
        .opcode (ir[IR_OP_MSB:IR_OP_LSB]),
        .inc_pc (cu.IncPC),
        .result (alu_result)
    );

    // Z has no enable: it follows the ALU on every edge it is not being driven onto the bus.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            z       <= '0;
            hi      <= '0;
            lo      <= '0;
            in_port <= '0;
            out_reg <= '0;
            con     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_load[i]) gpr[i] <= bus;
            end
            if (cu.PCIn)  pc      <= bus;
            if (cu.IRIn)  ir      <= bus;
            if (cu.MARIn) mar     <= bus;
            if (cu.MDRIn) mdr     <= cu.read ? cu.Mdatain : bus;
            if (cu.YIn)   y       <= bus;
            if (cu.HiIn)  hi      <= bus;
            if (cu.LoIn)  lo      <= bus;
            if (cu.InIn)  in_port <= cu.Mdatain;
            if (cu.OutIn) out_reg <= bus;
            if (!cu.Zlowout && !cu.Zhighout) z <= alu_result;
            if (cu.CIn)   con     <= con_next;
        end
    end

    assign cu.out_port = out_reg;
    assign cu.con_out  = con;
    assign cu.bus_mon  = bus;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the datapath; expected values are hand-computed.
module tb_datapath;
    import datapath_pkg::*;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    datapath_if cu ();

    datapath dut (
        .clk (clk),
        .clr (clr),
        .cu  (cu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        cu.read = 0; cu.write = 0;
        cu.PCout = 0; cu.Zlowout = 0; cu.Zhighout = 0; cu.MDRout = 0;
        cu.Cout = 0; cu.IN_Portout = 0; cu.LOout = 0; cu.HIout = 0;
        cu.MARIn = 0; cu.PCIn = 0; cu.MDRIn = 0; cu.IRIn = 0; cu.YIn = 0;
        cu.HiIn = 0; cu.LoIn = 0; cu.InIn = 0; cu.OutIn = 0;
        cu.IncPC = 0; cu.CIn = 0; cu.Gra = 0; cu.Grb = 0; cu.Grc = 0;
        cu.RIn = 0; cu.Rout = 0; cu.BAout = 0; cu.RegIn = '0; cu.Regout = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_in(input logic [31:0] val);
        cu.Mdatain = val; cu.InIn = 1; tick();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        load_in(val); cu.IN_Portout = 1; cu.RegIn[idx] = 1'b1; tick();
    endtask

    task automatic load_ir(input logic [31:0] val);
        load_in(val); cu.IN_Portout = 1; cu.IRIn = 1; tick();
    endtask

    task automatic load_y(input logic [31:0] val);
        load_in(val); cu.IN_Portout = 1; cu.YIn = 1; tick();
    endtask

    task automatic test_reset();
        clr = 0; tick(); tick(); clr = 1;
        load_reg(1, 32'hA5A5_0001);
        load_ir(32'h0008_0000);
        load_in(32'h0000_0100);
        cu.IN_Portout = 1; cu.PCIn = 1; cu.OutIn = 1; cu.CIn = 1; tick();
        checks++; if (dut.pc !== 32'h100) begin failures++; $display("[TB] FAIL preload_pc got=%h exp=%h", dut.pc, 32'h100); end
        checks++; if (cu.out_port !== 32'h100) begin failures++; $display("[TB] FAIL preload_out got=%h exp=%h", cu.out_port, 32'h100); end
        checks++; if (cu.con_out !== 1'b1) begin failures++; $display("[TB] FAIL preload_con got=%b exp=1", cu.con_out); end
        checks++; if (dut.gpr[1] !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL preload_r1 got=%h exp=%h", dut.gpr[1], 32'hA5A5_0001); end
        clr = 0; cu.IN_Portout = 1; cu.PCIn = 1; tick(); clr = 1;
        checks++; if (dut.pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", dut.pc); end
        checks++; if (dut.ir !== 32'h0) begin failures++; $display("[TB] FAIL reset_ir got=%h exp=0", dut.ir); end
        checks++; if (dut.z !== 64'h0) begin failures++; $display("[TB] FAIL reset_z got=%h exp=0", dut.z); end
        checks++; if (dut.gpr[1] !== 32'h0) begin failures++; $display("[TB] FAIL reset_r1 got=%h exp=0", dut.gpr[1]); end
        checks++; if (cu.out_port !== 32'h0) begin failures++; $display("[TB] FAIL reset_out got=%h exp=0", cu.out_port); end
        checks++; if (cu.con_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_con got=%b exp=0", cu.con_out); end
    endtask

    task automatic test_fetch();
        cu.PCout = 1; cu.MARIn = 1; cu.IncPC = 1; tick();
        checks++; if (dut.mar !== 32'h0) begin failures++; $display("[TB] FAIL fetch_mar got=%h exp=0", dut.mar); end
        checks++; if (dut.z !== 64'h1) begin failures++; $display("[TB] FAIL fetch_z got=%h exp=1", dut.z); end
        cu.Zlowout = 1; cu.PCIn = 1; tick();
        cu.Mdatain = 32'h0080_0055; cu.read = 1; cu.MDRIn = 1; tick();
        checks++; if (dut.pc !== 32'h1) begin failures++; $display("[TB] FAIL fetch_pc got=%h exp=1", dut.pc); end
        checks++; if (dut.mdr !== 32'h0080_0055) begin failures++; $display("[TB] FAIL fetch_mdr got=%h exp=%h", dut.mdr, 32'h0080_0055); end
        cu.MDRout = 1; cu.IRIn = 1; tick();
        checks++; if (dut.ir !== 32'h0080_0055) begin failures++; $display("[TB] FAIL fetch_ir got=%h exp=%h", dut.ir, 32'h0080_0055); end
    endtask

    task automatic test_ld();
        cu.Grb = 1; cu.BAout = 1; cu.YIn = 1; #1;
        checks++; if (cu.bus_mon !== 32'h0) begin failures++; $display("[TB] FAIL ld_base_bus got=%h exp=0", cu.bus_mon); end
        tick();
        checks++; if (dut.y !== 32'h0) begin failures++; $display("[TB] FAIL ld_y got=%h exp=0", dut.y); end
        cu.Cout = 1; tick();
        checks++; if (dut.z !== 64'h55) begin failures++; $display("[TB] FAIL ld_z got=%h exp=55", dut.z); end
        cu.Zlowout = 1; cu.MARIn = 1; tick();
        checks++; if (dut.mar !== 32'h55) begin failures++; $display("[TB] FAIL ld_mar got=%h exp=55", dut.mar); end
        cu.Mdatain = 32'h1234_5678; cu.read = 1; cu.MDRIn = 1; tick();
        cu.MDRout = 1; cu.Gra = 1; cu.RIn = 1; tick();
        checks++; if (dut.gpr[1] !== 32'h1234_5678) begin failures++; $display("[TB] FAIL ld_r1 got=%h exp=%h", dut.gpr[1], 32'h1234_5678); end
    endtask

    task automatic test_baout();
        load_reg(0, 32'hDEAD_0000);
        cu.Grb = 1; cu.BAout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h0) begin failures++; $display("[TB] FAIL ba_r0 got=%h exp=0", cu.bus_mon); end
        idle(); cu.Regout[0] = 1'b1; #1;
        checks++; if (cu.bus_mon !== 32'hDEAD_0000) begin failures++; $display("[TB] FAIL regout_r0 got=%h exp=%h", cu.bus_mon, 32'hDEAD_0000); end
        idle(); cu.Grb = 1; cu.Rout = 1; #1;
        checks++; if (cu.bus_mon !== 32'hDEAD_0000) begin failures++; $display("[TB] FAIL rout_r0 got=%h exp=%h", cu.bus_mon, 32'hDEAD_0000); end
        idle(); cu.Gra = 1; cu.BAout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h1234_5678) begin failures++; $display("[TB] FAIL ba_r1 got=%h exp=%h", cu.bus_mon, 32'h1234_5678); end
        idle();
    endtask

    task automatic test_sub();
        load_reg(2, 32'd7);
        load_reg(3, 32'd9);
        load_ir({OP_SUB, 27'b0});
        cu.Regout[2] = 1'b1; cu.YIn = 1; tick();
        cu.Regout[3] = 1'b1; tick();
        checks++; if (dut.z !== 64'h0000_0000_FFFF_FFFE) begin failures++; $display("[TB] FAIL sub_z got=%h exp=%h", dut.z, 64'h0000_0000_FFFF_FFFE); end
        cu.Zlowout = 1; #1;
        checks++; if (cu.bus_mon !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL sub_zlow_bus got=%h exp=%h", cu.bus_mon, 32'hFFFF_FFFE); end
        idle(); cu.Zhighout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h0) begin failures++; $display("[TB] FAIL sub_zhigh_bus got=%h exp=0", cu.bus_mon); end
        idle();
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops [15];
        logic [31:0] av  [15];
        logic [31:0] bv  [15];
        logic [31:0] ev  [15];
        ops = '{OP_ADD, OP_ADD, OP_LDI, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR,
                OP_ROL, OP_NEG, OP_NOT, 5'd31, OP_ST, OP_ANDI, OP_ORI};
        av  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0A, 32'hF0F0_1234, 32'hF000_0000,
                32'h8000_0010, 32'h8000_0011, 32'h0000_00F1, 32'hF000_0001, 32'h1234,
                32'h0, 32'h1, 32'h5, 32'hFF, 32'hF0};
        bv  = '{32'h1, 32'h2, 32'h14, 32'h0FF0_FFFF, 32'h0000_000F,
                32'h4, 32'h4, 32'h24, 32'h8, 32'h5,
                32'h0F0F_0F0F, 32'h1, 32'h6, 32'h0F, 32'h0F};
        ev  = '{32'h8000_0000, 32'h1, 32'h1E, 32'h00F0_1234, 32'hF000_000F,
                32'h0800_0001, 32'h0000_0110, 32'h1000_000F, 32'h0000_01F0, 32'hFFFF_FFFB,
                32'hF0F0_F0F0, 32'h0, 32'h0B, 32'h0F, 32'hFF};
        for (int i = 0; i < 15; i++) begin
            load_ir({ops[i], 27'b0});
            load_y(av[i]);
            load_in(bv[i]);
            cu.IN_Portout = 1; tick();
            checks++;
            if (dut.z !== {32'h0, ev[i]}) begin
                failures++;
                $display("[TB] FAIL alu_op%0d(row %0d) got=%h exp=%h", ops[i], i, dut.z, {32'h0, ev[i]});
            end
        end
    endtask

    task automatic test_incpc();
        load_ir({OP_NOT, 27'b0});
        load_y(32'h77);
        load_in(32'h29);
        cu.IN_Portout = 1; cu.IncPC = 1; tick();
        checks++; if (dut.z !== 64'h2A) begin failures++; $display("[TB] FAIL incpc_z got=%h exp=2a", dut.z); end
    endtask

    task automatic test_mul_div();
        logic [4:0]  ops [3];
        logic [31:0] av  [3];
        logic [31:0] bv  [3];
        logic [63:0] ev  [3];
        ops = '{OP_MUL, OP_DIV, OP_DIV};
        av  = '{32'hFFFF_FFFD, 32'd17, 32'd17};
        bv  = '{32'd5, 32'd5, 32'd0};
`ifdef MUL_DIV_EN
        ev  = '{64'hFFFF_FFFF_FFFF_FFF1, {32'd2, 32'd3}, {32'd17, 32'hFFFF_FFFF}};
`else
        ev  = '{64'h0, 64'h0, 64'h0};
`endif
        for (int i = 0; i < 3; i++) begin
            load_ir({ops[i], 27'b0});
            load_y(av[i]);
            load_in(bv[i]);
            cu.IN_Portout = 1; tick();
            checks++;
            if (dut.z !== ev[i]) begin
                failures++;
                $display("[TB] FAIL muldiv_row%0d got=%h exp=%h", i, dut.z, ev[i]);
            end
        end
    endtask

    task automatic test_con();
        logic [31:0] irv [6];
        logic [31:0] bv  [6];
        logic        ev  [6];
        load_ir(32'h0008_0000);
        load_reg(4, 32'd0);
        cu.Regout[4] = 1'b1; cu.CIn = 1; tick();
        checks++; if (cu.con_out !== 1'b0) begin failures++; $display("[TB] FAIL con_ne_zero got=%b exp=0", cu.con_out); end
        load_reg(4, 32'd5);
        cu.Regout[4] = 1'b1; cu.CIn = 1; tick();
        checks++; if (cu.con_out !== 1'b1) begin failures++; $display("[TB] FAIL con_ne_five got=%b exp=1", cu.con_out); end
        irv = '{32'h0, 32'h0, 32'h0010_0000, 32'h0010_0000, 32'h0018_0000, 32'h0018_0000};
        bv  = '{32'h0, 32'h3, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        ev  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            load_ir(irv[i]);
            load_in(bv[i]);
            cu.IN_Portout = 1; cu.CIn = 1; tick();
            checks++;
            if (cu.con_out !== ev[i]) begin
                failures++;
                $display("[TB] FAIL con_row%0d got=%b exp=%b", i, cu.con_out, ev[i]);
            end
        end
    endtask

    task automatic test_priority();
        cu.PCout = 1; cu.MDRout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h1) begin failures++; $display("[TB] FAIL prio_pc_mdr got=%h exp=1", cu.bus_mon); end
        idle(); cu.MDRout = 1; cu.IN_Portout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h1234_5678) begin failures++; $display("[TB] FAIL prio_mdr_in got=%h exp=%h", cu.bus_mon, 32'h1234_5678); end
        idle(); cu.Regout[3] = 1'b1; cu.Regout[2] = 1'b1; #1;
        checks++; if (cu.bus_mon !== 32'd7) begin failures++; $display("[TB] FAIL prio_r2_r3 got=%h exp=7", cu.bus_mon); end
        idle();
        load_in(32'hAAAA_0000); cu.IN_Portout = 1; cu.HiIn = 1; tick();
        load_in(32'h0000_5555); cu.IN_Portout = 1; cu.LoIn = 1; tick();
        cu.Regout[1] = 1'b1; cu.HIout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h1234_5678) begin failures++; $display("[TB] FAIL prio_r1_hi got=%h exp=%h", cu.bus_mon, 32'h1234_5678); end
        idle(); cu.HIout = 1; cu.LOout = 1; #1;
        checks++; if (cu.bus_mon !== 32'hAAAA_0000) begin failures++; $display("[TB] FAIL prio_hi_lo got=%h exp=%h", cu.bus_mon, 32'hAAAA_0000); end
        idle(); cu.LOout = 1; cu.PCout = 1; #1;
        checks++; if (cu.bus_mon !== 32'h0000_5555) begin failures++; $display("[TB] FAIL prio_lo_pc got=%h exp=%h", cu.bus_mon, 32'h0000_5555); end
        idle();
        load_ir(32'h0004_0001);
        cu.Cout = 1; #1;
        checks++; if (cu.bus_mon !== 32'hFFFC_0001) begin failures++; $display("[TB] FAIL c_sext got=%h exp=%h", cu.bus_mon, 32'hFFFC_0001); end
        idle(); #1;
        checks++; if (cu.bus_mon !== 32'h0) begin failures++; $display("[TB] FAIL bus_idle got=%h exp=0", cu.bus_mon); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        clr        = 0;
        cu.Mdatain = '0;
        idle();
        test_reset();
        test_fetch();
        test_ld();
        test_baout();
        test_sub();
        test_alu_ops();
        test_incpc();
        test_mul_div();
        test_con();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
